// File: rtl/lib_voq_pkg.sv
// lib_voq_pkg: shared helpers for the virtual output queue.
//   onehot_chk - true when exactly one bit of the (zero-extended) vector is set
//   cnt_width  - width of an occupancy counter able to hold 0..depth
//   ERR_*      - bit positions of the sticky error vector (LIB_VOQ_ERR_EN builds)
package lib_voq_pkg;

    localparam int unsigned ERR_W         = 3;
    localparam int unsigned ERR_PUSH_FULL = 2;
    localparam int unsigned ERR_POP_EMPTY = 1;
    localparam int unsigned ERR_ONEHOT    = 0;

    function automatic logic onehot_chk(input logic [63:0] v);
        return (v != '0) && ((v & (v - 64'd1)) == '0);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lib_voq_chan.sv
// lib_voq_chan: one circular FIFO of DEPTH entries (any DEPTH >= 2).
//   clk, reset, ce   - clock, synchronous active-high reset, clock enable
//   push, wdata      - push request (already onehot-qualified) and data
//   pop              - pop request (already onehot-qualified)
//   ready            - can accept a push this cycle
//   not_empty, head  - head valid and first-word-fall-through head entry
//   near_full, count - free slots <= NEAR_FULL, registered occupancy
module lib_voq_chan
    import lib_voq_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NEAR_FULL = 1,
    // Derived; leave at default.
    parameter int unsigned CW        = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             ready,
    output logic             not_empty,
    output logic             near_full,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;
    logic [CW-1:0]    free;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A pop on an empty FIFO is ignored, so an empty FIFO never bypasses.
    assign do_pop    = pop && (cnt_q != '0);
    assign ready     = (cnt_q != DEPTH_C) || do_pop;
    assign do_push   = push && ready;
    assign not_empty = (cnt_q != '0);
    assign free      = DEPTH_C - cnt_q;
    assign near_full = (32'(free) <= NEAR_FULL);
    assign count     = cnt_q;
    assign head      = mem[rd_q];

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        if (do_pop) begin
            rd_d = ptr_inc(rd_q);
        end
        if (do_push) begin
            wr_d = ptr_inc(wr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (ce) begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage carries no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (!reset && ce && do_push) begin
            mem[wr_q] <= wdata;
        end
    end

endmodule

// File: rtl/lib_voq_param.sv
// lib_voq_param: M-channel virtual output queue for router input ports.
//   clk, reset, ce  - clock, synchronous active-high reset, clock enable
//   i_data          - upstream word, written to the VC flagged in i_data_val
//   i_data_val      - onehot upstream valid, [0:M-1] so VC 0 is the MSB
//   o_en            - per-VC ready to upstream (combinational on i_en)
//   o_data          - head of the VC selected by i_en; 0 unless i_en is onehot
//   o_data_val      - per-VC not-empty
//   i_en            - onehot dequeue/select from the switch
//   o_near_full     - per-VC free slots <= NEAR_FULL
//   o_count         - packed occupancies, VC 0 in the most significant field
//   o_err           - sticky {push-full, pop-empty, non-onehot}; only when
//                     LIB_VOQ_ERR_EN is defined
module lib_voq_param
    import lib_voq_pkg::*;
#(
    parameter int unsigned M         = 5,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NEAR_FULL = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           ce,
    input  logic [WIDTH-1:0]               i_data,
    input  logic [0:M-1]                   i_data_val,
    output logic [0:M-1]                   o_en,
    output logic [WIDTH-1:0]               o_data,
    output logic [0:M-1]                   o_data_val,
    input  logic [0:M-1]                   i_en,
    output logic [0:M-1]                   o_near_full,
    output logic [M*cnt_width(DEPTH)-1:0]  o_count
`ifdef LIB_VOQ_ERR_EN
    ,
    output logic [ERR_W-1:0]               o_err
`endif
);

    localparam int unsigned CW = cnt_width(DEPTH);

    logic             val_ok, en_ok;
    logic [0:M-1]     push, pop;
    logic [WIDTH-1:0] head [M];
    logic [CW-1:0]    cnt  [M];

    assign val_ok = onehot_chk(64'(i_data_val));
    assign en_ok  = onehot_chk(64'(i_en));
    // Non-onehot selects are dropped entirely. o_en is built from the qualified
    // pop, so a full VC never advertises room on a pop that will not happen.
    assign push   = val_ok ? i_data_val : '0;
    assign pop    = en_ok ? i_en : '0;

    for (genvar g = 0; g < M; g++) begin : g_chan
        lib_voq_chan #(
            .DEPTH     (DEPTH),
            .WIDTH     (WIDTH),
            .NEAR_FULL (NEAR_FULL)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .ce        (ce),
            .push      (push[g]),
            .wdata     (i_data),
            .pop       (pop[g]),
            .ready     (o_en[g]),
            .not_empty (o_data_val[g]),
            .near_full (o_near_full[g]),
            .count     (cnt[g]),
            .head      (head[g])
        );
        assign o_count[(M-g)*CW-1 -: CW] = cnt[g];
    end

    // pop is onehot or zero, so an OR-mux selects at most one head.
    always_comb begin
        o_data = '0;
        for (int i = 0; i < M; i++) begin
            if (pop[i]) begin
                o_data = o_data | head[i];
            end
        end
    end

`ifdef LIB_VOQ_ERR_EN
    logic [ERR_W-1:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (((i_data_val != '0) && !val_ok) || ((i_en != '0) && !en_ok)) begin
            err_d[ERR_ONEHOT] = 1'b1;
        end
        if ((push & ~o_en) != '0) begin
            err_d[ERR_PUSH_FULL] = 1'b1;
        end
        if ((pop & ~o_data_val) != '0) begin
            err_d[ERR_POP_EMPTY] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= '0;
        end else if (ce) begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;

    always @(posedge clk) begin
        if (!reset && ce) begin
            assert ((i_data_val == '0) || val_ok)
                else $warning("lib_voq_param: i_data_val not onehot");
            assert ((i_en == '0) || en_ok)
                else $warning("lib_voq_param: i_en not onehot");
        end
    end
`endif

endmodule
